// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: legal parameter ranges and a single Galois step
// evaluated on a 64-bit container so any WIDTH from 3 to 64 can use it.
package lfsr_pkg;

    localparam int LFSR_WIDTH_MIN = 3;
    localparam int LFSR_WIDTH_MAX = 64;
    localparam int LFSR_STEP_MIN  = 1;

    // Returns {next_state, out_bit}; bits at or above width stay zero.
    function automatic logic [64:0] lfsr_step(input logic [63:0] state,
                                              input logic [63:0] poly,
                                              input int          width);
        logic [63:0] nxt;
        logic        fb;
        fb     = state[width-1];
        nxt    = '0;
        nxt[0] = fb;
        for (int k = 1; k < 64; k++) begin
            if (k < width) begin
                nxt[k] = state[k-1] ^ (poly[k] & fb);
            end
        end
        return {nxt, fb};
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational stepper: applies STEP Galois steps to state in one cycle.
// bits[STEP-1] is the first bit shifted out.
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] POLY  = 26'h182,
    parameter int               STEP  = 1
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state,
    output logic [STEP-1:0]  bits
);

    localparam logic [63:0] POLY_EXT = 64'(POLY);

    logic [63:0] walk;
    logic [64:0] step_r;

    always_comb begin
        walk             = '0;
        step_r           = '0;
        bits             = '0;
        walk[WIDTH-1:0]  = state;
        for (int i = 0; i < STEP; i++) begin
            step_r          = lfsr_step(walk, POLY_EXT, WIDTH);
            bits[STEP-1-i]  = step_r[0];
            walk            = step_r[64:1];
        end
        next_state = walk[WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// Galois LFSR stream source with valid/ready output, seed load and wrap flag.
// Optional LFSR_ERR_INJ_EN adds err_inj to flip m_data[0] of one beat.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 26,
    parameter logic [WIDTH-1:0] POLY  = 26'h182,
    parameter int               STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
`ifdef LFSR_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [STEP-1:0]  m_data,
    output logic [WIDTH-1:0] state,
    output logic             wrap
);

    if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_bad_width
        $error("lfsr_stream_gen: WIDTH out of range");
    end
    if (STEP < LFSR_STEP_MIN || STEP > WIDTH) begin : g_bad_step
        $error("lfsr_stream_gen: STEP out of range");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
    logic [STEP-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] adv_state;
    logic [STEP-1:0]  adv_bits;
    logic [WIDTH-1:0] load_val;
    logic [STEP-1:0]  inj_mask;
    logic             advance;

    lfsr_advance #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .STEP  (STEP)
    ) u_advance (
        .state      (state_q),
        .next_state (adv_state),
        .bits       (adv_bits)
    );

    // A zero seed would lock the register up, so it is mapped to 1.
    assign load_val = (seed == '0) ? WIDTH'(1) : seed;
    assign advance  = enable & ~load & (~valid_q | m_ready);

`ifdef LFSR_ERR_INJ_EN
    logic err_pend_q, err_pend_d;

    assign inj_mask = STEP'(err_pend_q | err_inj);

    always_comb begin
        err_pend_d = err_pend_q | err_inj;
        if (load || (advance && state_q != '0)) begin
            err_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end
`else
    assign inj_mask = '0;
`endif

    always_comb begin
        state_d    = state_q;
        ref_seed_d = ref_seed_q;
        data_d     = data_q;
        wrap_d     = wrap_q;
        valid_d    = valid_q & ~m_ready;
        if (load) begin
            state_d    = load_val;
            ref_seed_d = load_val;
            valid_d    = 1'b0;
            wrap_d     = 1'b0;
        end else if (advance) begin
            // An all-zero state is recovered without presenting a beat.
            if (state_q == '0) begin
                state_d = WIDTH'(1);
            end else begin
                state_d = adv_state;
                data_d  = adv_bits ^ inj_mask;
                valid_d = 1'b1;
                wrap_d  = (adv_state == ref_seed_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WIDTH'(1);
            ref_seed_q <= WIDTH'(1);
            data_q     <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_seed_q <= ref_seed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign state   = state_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: STEP=1 and STEP=4 instances share stimulus and
// are checked against a polynomial-form model through per-instance queues.
module tb_lfsr_stream_gen;

    localparam int         W = 4;
    localparam logic [3:0] P = 4'h8;

    logic       clk = 1'b0;
    logic       rst_n, enable, load, m_ready;
    logic [3:0] seed;
`ifdef LFSR_ERR_INJ_EN
    logic       err_inj;
`endif

    logic       a_valid, a_wrap, b_valid, b_wrap;
    logic [0:0] a_data;
    logic [3:0] b_data, a_state, b_state;

    always #5 clk = ~clk;

    lfsr_stream_gen #(.WIDTH(W), .POLY(P), .STEP(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .seed    (seed),
`ifdef LFSR_ERR_INJ_EN
        .err_inj (err_inj),
`endif
        .m_valid (a_valid),
        .m_ready (m_ready),
        .m_data  (a_data),
        .state   (a_state),
        .wrap    (a_wrap)
    );

    lfsr_stream_gen #(.WIDTH(W), .POLY(P), .STEP(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .seed    (seed),
`ifdef LFSR_ERR_INJ_EN
        .err_inj (err_inj),
`endif
        .m_valid (b_valid),
        .m_ready (m_ready),
        .m_data  (b_data),
        .state   (b_state),
        .wrap    (b_wrap)
    );

    typedef struct {
        logic [3:0] data;
        logic       wrap;
        logic [3:0] st;
    } beat_t;

    beat_t      qa[$];
    beat_t      qb[$];
    logic [3:0] ma, mb, ref_s;
    logic       inj_a, inj_b;
    int         tests = 0;
    int         fails = 0;

    // x^4+x^3+1: shift left, xor taps 1001 when the top bit falls out.
    function automatic logic [4:0] mstep(input logic [3:0] s);
        logic [3:0] n;
        n = {s[2:0], 1'b0} ^ (s[3] ? 4'b1001 : 4'b0000);
        return {n, s[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a();
        beat_t      e;
        logic [4:0] r;
        r      = mstep(ma);
        ma     = r[4:1];
        e.data = {3'b000, r[0] ^ inj_a};
        inj_a  = 1'b0;
        e.wrap = (ma == ref_s);
        e.st   = ma;
        qa.push_back(e);
    endtask

    task automatic push_b();
        beat_t      e;
        logic [4:0] r;
        e.data = '0;
        for (int i = 0; i < 4; i++) begin
            r             = mstep(mb);
            mb            = r[4:1];
            e.data[3-i]   = r[0];
        end
        e.data[0] = e.data[0] ^ inj_b;
        inj_b     = 1'b0;
        e.wrap    = (mb == ref_s);
        e.st      = mb;
        qb.push_back(e);
    endtask

    task automatic sync_q();
        if (qa.size() == 0) push_a();
        if (qb.size() == 0) push_b();
    endtask

    task automatic sb();
        beat_t e;
        if (a_valid && m_ready) begin
            if (qa.size() == 0) push_a();
            e = qa.pop_front();
            check("a_data", 32'(a_data), 32'(e.data));
            check("a_wrap", 32'(a_wrap), 32'(e.wrap));
            check("a_state", 32'(a_state), 32'(e.st));
        end
        if (b_valid && m_ready) begin
            if (qb.size() == 0) push_b();
            e = qb.pop_front();
            check("b_data", 32'(b_data), 32'(e.data));
            check("b_wrap", 32'(b_wrap), 32'(e.wrap));
            check("b_state", 32'(b_state), 32'(e.st));
        end
    endtask

    task automatic tick();
        sb();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] s);
        load = 1'b1;
        seed = s;
        @(posedge clk);
        #1;
        load  = 1'b0;
        qa.delete();
        qb.delete();
        ref_s = (s == 4'd0) ? 4'd1 : s;
        ma    = ref_s;
        mb    = ref_s;
        inj_a = 1'b0;
        inj_b = 1'b0;
    endtask

    initial begin
        int wraps_a, wraps_b;
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        m_ready = 1'b0;
        seed    = 4'd0;
        inj_a   = 1'b0;
        inj_b   = 1'b0;
        ma      = 4'd1;
        mb      = 4'd1;
        ref_s   = 4'd1;
`ifdef LFSR_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_state", 32'(a_state), 32'd1);
        check("rst_data", 32'(a_data), 32'd0);
        check("rst_wrap", 32'(a_wrap), 32'd0);
        check("rst_b_data", 32'(b_data), 32'd0);
        rst_n = 1'b1;

        // Seed 1, free-running at full throughput through more than a period.
        do_load(4'b0001);
        check("load_state", 32'(a_state), 32'd1);
        check("load_valid", 32'(a_valid), 32'd0);
        enable  = 1'b1;
        m_ready = 1'b1;
        wraps_a = 0;
        wraps_b = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("run_valid", 32'(a_valid), 32'd1);
            if (i == 1) check("b_first", 32'(b_data), 32'b0001);
            if (i == 4) check("a_state4", 32'(a_state), 32'b1001);
            if (i <= 15) begin
                wraps_a += int'(a_wrap);
                wraps_b += int'(b_wrap);
            end
        end
        check("a_wraps15", 32'(wraps_a), 32'd1);
        check("b_wraps15", 32'(wraps_b), 32'd1);

        // Backpressure: presented beat must hold, then resume seamlessly.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            sync_q();
            check("stall_valid", 32'(a_valid), 32'd1);
            check("stall_a_data", 32'(a_data), 32'(qa[0].data));
            check("stall_a_state", 32'(a_state), 32'(qa[0].st));
            check("stall_a_wrap", 32'(a_wrap), 32'(qa[0].wrap));
            check("stall_b_data", 32'(b_data), 32'(qb[0].data));
        end
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Zero seed maps to 1; load during a stalled beat discards it.
        do_load(4'd0);
        check("seed0_a_state", 32'(a_state), 32'd1);
        check("seed0_b_state", 32'(b_state), 32'd1);
        check("seed0_valid", 32'(a_valid), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        m_ready = 1'b0;
        tick();
        check("pend_valid", 32'(a_valid), 32'd1);
        m_ready = 1'b1;
        do_load(4'h5);
        check("drop_a_valid", 32'(a_valid), 32'd0);
        check("drop_b_valid", 32'(b_valid), 32'd0);
        check("drop_state", 32'(a_state), 32'h5);
        for (int i = 0; i < 6; i++) tick();

        // Mid-stream reset, then enable=0 drains the one pending beat.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        ma    = 4'd1;
        mb    = 4'd1;
        ref_s = 4'd1;
        check("mrst_valid", 32'(a_valid), 32'd0);
        check("mrst_state", 32'(a_state), 32'd1);
        check("mrst_wrap", 32'(a_wrap), 32'd0);
        check("mrst_b_data", 32'(b_data), 32'd0);
        tick();
        enable = 1'b0;
        tick();
        check("drain_valid", 32'(a_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_valid", 32'(a_valid), 32'd0);
            check("idle_a_state", 32'(a_state), 32'(ma));
            check("idle_b_state", 32'(b_state), 32'(mb));
        end

`ifdef LFSR_ERR_INJ_EN
        do_load(4'b0001);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sync_q();
        err_inj = 1'b1;
        inj_a   = 1'b1;
        inj_b   = 1'b1;
        tick();
        err_inj = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
